// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the writeback register file.
// Optional same-cycle write-to-read bypass: define REGFILE_WB_BYPASS_EN.
package regfile_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam logic BANK_GPR = 1'b0;
    localparam logic BANK_FPR = 1'b1;

    // Registered result bundle shared with the ALU wrapper output
    typedef struct packed {
        logic                  enable;
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
        logic                  float;
    } wb_bus_t;

    // GPR r0 is hardwired to zero: never written, never pending
    function automatic logic is_gpr_zero(input logic bank, input logic [REG_ADDR_W-1:0] addr);
        return (bank == BANK_GPR) && (addr == '0);
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback, read-port and issue-mark signals between decode/execute and the register file.
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic                  wb_enable;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]      wb_data;
    logic                  wb_float;

    logic                  rd_en;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic                  rs_float;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic                  rt_float;
    logic [WIDTH-1:0]      rs_data;
    logic [WIDTH-1:0]      rt_data;
    logic                  rs_hazard;
    logic                  rt_hazard;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_addr;
    logic                  issue_float;
    logic                  busy;

    modport master (
        output wb_enable, wb_addr, wb_data, wb_float,
        output rd_en, rs_addr, rs_float, rt_addr, rt_float,
        output issue_valid, issue_addr, issue_float,
        input  rs_data, rt_data, rs_hazard, rt_hazard, busy
    );

    modport slave (
        input  wb_enable, wb_addr, wb_data, wb_float,
        input  rd_en, rs_addr, rs_float, rt_addr, rt_float,
        input  issue_valid, issue_addr, issue_float,
        output rs_data, rt_data, rs_hazard, rt_hazard, busy
    );

endinterface

// File: rtl/regfile_writeback_scoreboard.sv
// Per-register pending bits for both banks; issue sets, writeback clears, set wins.
module regfile_writeback_scoreboard
    import regfile_writeback_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid_i,
    input  logic [REG_ADDR_W-1:0] iss_addr_i,
    input  logic                  iss_bank_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic                  wb_bank_i,
    output logic [1:0][NREG-1:0]  pend_o,
    output logic                  busy_o
);

    logic [1:0][NREG-1:0] pend_q, pend_d;
    logic                 busy_q;

    always_comb begin
        pend_d = pend_q;
        if (wb_valid_i)
            pend_d[wb_bank_i][wb_addr_i] = 1'b0;
        // Applied after the clear so a re-issue of the retiring register stays pending
        if (iss_valid_i && !is_gpr_zero(iss_bank_i, iss_addr_i))
            pend_d[iss_bank_i][iss_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            busy_q <= |pend_d;
        end
    end

    assign pend_o = pend_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_writeback.sv
// GPR/FPR register file with two registered read ports and a RAW scoreboard.
// Optional same-cycle writeback bypass on the read ports: define REGFILE_WB_BYPASS_EN.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    regfile_writeback_if.slave rf
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             haz;
    } rd_t;

    wb_bus_t              wb;
    logic                 wr_ok;
    logic [WIDTH-1:0]     gpr_q [NREG];
    logic [WIDTH-1:0]     fpr_q [NREG];
    logic [1:0][NREG-1:0] pend;
    logic                 busy;
    rd_t                  rs_d, rt_d, rs_q, rt_q;

    assign wb    = '{enable: rf.wb_enable, addr: rf.wb_addr, data: rf.wb_data, float: rf.wb_float};
    assign wr_ok = wb.enable && !is_gpr_zero(wb.float, wb.addr);

    regfile_writeback_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .iss_valid_i (rf.issue_valid),
        .iss_addr_i  (rf.issue_addr),
        .iss_bank_i  (rf.issue_float),
        .wb_valid_i  (wb.enable),
        .wb_addr_i   (wb.addr),
        .wb_bank_i   (wb.float),
        .pend_o      (pend),
        .busy_o      (busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
                fpr_q[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wb.float == BANK_FPR) fpr_q[wb.addr] <= wb.data;
            else                      gpr_q[wb.addr] <= wb.data;
        end
    end

    function automatic rd_t src_read(input logic bank, input logic [REG_ADDR_W-1:0] addr);
        rd_t r;
        r.data = (bank == BANK_FPR) ? fpr_q[addr] : gpr_q[addr];
        r.haz  = pend[bank][addr];
`ifdef REGFILE_WB_BYPASS_EN
        // Retiring producer: forward its value; only a same-cycle re-issue keeps the hazard
        if (wr_ok && bank == wb.float && addr == wb.addr) begin
            r.data = wb.data;
            r.haz  = rf.issue_valid && rf.issue_float == bank && rf.issue_addr == addr;
        end
`endif
        return r;
    endfunction

    always_comb begin
        rs_d = src_read(rf.rs_float, rf.rs_addr);
        rt_d = src_read(rf.rt_float, rf.rt_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q <= '0;
            rt_q <= '0;
        end else if (rf.rd_en) begin
            rs_q <= rs_d;
            rt_q <= rt_d;
        end
    end

    assign rf.rs_data   = rs_q.data;
    assign rf.rt_data   = rt_q.data;
    assign rf.rs_hazard = rs_q.haz;
    assign rf.rt_hazard = rt_q.haz;
    assign rf.busy      = busy;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Receiving end of the execution writeback bus. It is the register file and scoreboard that consume the registered enable/addr/data/float result from the ALU stage.
- Holds two 32x32 banks: integer (GPR) and float (FPR). It has two registered read ports for rs and rt.
- Tracks in-flight destinations so decode can stall on read-after-write (RAW) hazards.
- Sits between decode/issue (reads, issue marks) and the execution-stage writeback register.

Parameters:
- NREG, 32, registers per bank; the address width is fixed at 5.
- WIDTH, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_enable  in  1  writeback valid.
- wb_addr  in  5  writeback destination.
- wb_data  in  32  writeback value.
- wb_float  in  1  1 selects the FPR bank, 0 selects the GPR bank.
- rd_en  in  1  capture read addresses this cycle.
- rs_addr  in  5  source register 1.
- rs_float  in  1  bank select for source 1.
- rt_addr  in  5  source register 2.
- rt_float  in  1  bank select for source 2.
- rs_data  out  32  source 1 value, registered.
- rt_data  out  32  source 2 value, registered.
- rs_hazard  out  1  source 1 was pending when sampled, registered.
- rt_hazard  out  1  source 2 was pending when sampled, registered.
- issue_valid  in  1  an instruction with a destination has issued.
- issue_addr  in  5  destination of the issued instruction.
- issue_float  in  1  bank of the issued instruction's destination.
- busy  out  1  any pending bit set, registered.

Behaviour:
- Reset (async, active-high):
  - All 64 registers cleared to 0.
  - All pending bits cleared.
  - rs_data, rt_data, rs_hazard, rt_hazard and busy all 0.
  - Reset mid-operation discards in-flight writebacks and issue marks.
- Write:
  - On a rising edge with wb_enable=1, bank[wb_float][wb_addr] <= wb_data.
  - GPR r0: writes are ignored and it always reads 0.
  - FPR f0 is an ordinary register.
- Read:
  - Latency 1. On a rising edge with rd_en=1, rs_data/rt_data/rs_hazard/rt_hazard update from the sampled addresses.
  - With rd_en=0, all four outputs hold their previous values.
- Scoreboard: one pending bit per register per bank.
  - issue_valid sets pending[issue_float][issue_addr].
  - wb_enable clears pending[wb_float][wb_addr].
  - Set and clear of the same register in the same cycle: set wins (a new producer is in flight).
  - GPR r0 is never set pending.
  - Issue and writeback to different registers in the same cycle both take effect.
- Hazard:
  - rs_hazard = pending[rs_float][rs_addr] as of the pre-edge state, except when it is cleared by the same-cycle writeback (see the optional feature).
  - rt_hazard is computed identically.
  - A bank mismatch (same address, other bank) is never a hazard or a bypass.
- busy: registered OR of all next-state pending bits.
- Writeback with no matching pending bit (not issued) is legal: the register is written and the scoreboard is unchanged.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - A read sampling the register written in the same cycle (same bank and address, wb_enable=1, not GPR r0) returns wb_data.
  - That read's hazard is 0 unless the same register is also re-issued that cycle.
- Undefined:
  - The same-cycle read returns the old register contents.
  - The hazard reflects the pre-edge pending bit, so it is 1 if the register was pending.

Decomposition:
- Shared package:
  - REG_ADDR_W=5 and WORD_W=32.
  - Bank select constants BANK_GPR=0 and BANK_FPR=1.
  - Writeback bundle typedef {enable, addr[4:0], data[31:0], float}, shared with the ALU wrapper output.
- One natural sub-module: regfile_scoreboard, holding the 2x32 pending bits, set/clear priority and busy generation.
- Storage and read ports stay in the top module.

Test Plan:
- Reset, then write GPR 5 = 0xDEADBEEF, then read rs=GPR5, rt=FPR5 next cycle -> rs_data=0xDEADBEEF, rt_data=0, both hazards 0.
- Write GPR0 = 0x12345678, then read GPR0; issue GPR0 -> rs_data=0, hazard 0, busy stays 0.
- Issue FPR3, read FPR3 and GPR3 next cycle -> rs_hazard=1, rt_hazard=0, busy=1. Then writeback FPR3 = 0x3F800000 -> busy=0 next cycle; a subsequent read gives 0x3F800000, hazard 0.
- Same-cycle writeback GPR7 = 0xA5A5A5A5 and read GPR7, with GPR7 previously 0x1 and pending:
  - With REGFILE_WB_BYPASS_EN -> rs_data=0xA5A5A5A5, hazard 0.
  - Without -> rs_data=0x1, hazard 1.
- Same-cycle issue GPR9 and writeback GPR9 -> pending stays set; the next read of GPR9 shows hazard 1 and busy 1.
- Assert reset asynchronously between clock edges with 3 registers pending and rs_data nonzero -> all outputs go to 0 immediately, without waiting for an edge; after release all registers read 0 and busy=0.
